// File: rtl/lcd_pattern_sched_if.sv
// Pixel-path bundle between the LCD timing generator and the pattern scheduler:
// sync/strobe/coordinates towards the scheduler, RGB565 pixel back.
interface lcd_pattern_sched_if;
    logic        lcd_vsy;
    logic        lcd_de;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [15:0] pix_rgb;

    modport master (
        output lcd_vsy, lcd_de, pix_x, pix_y,
        input  pix_rgb
    );

    modport slave (
        input  lcd_vsy, lcd_de, pix_x, pix_y,
        output pix_rgb
    );
endinterface

// File: rtl/lcd_pattern_sched.sv
// Test-pattern scheduler for the RGB565 LCD path: picks one of six patterns,
// advancing on a frame count or a debounced key press, committed at vsync.
module lcd_pattern_sched #(
    parameter int H_ACT          = 640,
    parameter int FRAMES_PER_PAT = 60,
    parameter int DEB_CYCLES     = 250000
) (
    input  logic               clk,
    input  logic               rst,
    lcd_pattern_sched_if.slave lcd,
    input  logic               auto_en,
    input  logic               key_n,
    output logic [2:0]         pat_id,
    output logic               frame_tick
);

    localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int FCNT_W = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;
    localparam int BAR_W  = H_ACT / 8;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FRAMES_PER_PAT - 1);

    logic              vsy_q, vsy_d;
    logic              frame_tick_q, frame_tick_d;
    logic              key_s1_q, key_s1_d;
    logic              key_s2_q, key_s2_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              key_acc_q, key_acc_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              pending_q, pending_d;
    logic [2:0]        pat_id_q, pat_id_d;
    logic [15:0]       pix_rgb_q, pix_rgb_d;

    logic              press;
    logic              auto_req;
    logic              commit;
    logic [2:0]        bar_idx;
    logic [15:0]       bar_rgb;
    logic [15:0]       pat_rgb;

    // Only bit 5 of the row selects the checkerboard phase.
    logic unused_pix_y;
    assign unused_pix_y = ^{lcd.pix_y[9:6], lcd.pix_y[4:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            vsy_q        <= 1'b1;
            frame_tick_q <= 1'b0;
            key_s1_q     <= 1'b1;
            key_s2_q     <= 1'b1;
            deb_cnt_q    <= '0;
            key_acc_q    <= 1'b1;
            fcnt_q       <= '0;
            pending_q    <= 1'b0;
            pat_id_q     <= 3'd0;
            pix_rgb_q    <= 16'h0000;
        end else begin
            vsy_q        <= vsy_d;
            frame_tick_q <= frame_tick_d;
            key_s1_q     <= key_s1_d;
            key_s2_q     <= key_s2_d;
            deb_cnt_q    <= deb_cnt_d;
            key_acc_q    <= key_acc_d;
            fcnt_q       <= fcnt_d;
            pending_q    <= pending_d;
            pat_id_q     <= pat_id_d;
            pix_rgb_q    <= pix_rgb_d;
        end
    end

    always_comb begin
        vsy_d        = lcd.lcd_vsy;
        frame_tick_d = vsy_q & ~lcd.lcd_vsy;
        key_s1_d     = key_n;
        key_s2_d     = key_s1_q;

        deb_cnt_d = deb_cnt_q;
        key_acc_d = key_acc_q;
        press     = 1'b0;
        if (key_s2_q == key_acc_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            key_acc_d = key_s2_q;
            deb_cnt_d = '0;
            press     = ~key_s2_q;
        end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end

        auto_req = 1'b0;
        fcnt_d   = fcnt_q;
        if (!auto_en) begin
            fcnt_d = '0;
        end else if (frame_tick_q) begin
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d   = '0;
                auto_req = 1'b1;
            end else begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
        end

        // A request arriving on the tick itself is folded into that tick's commit.
        commit    = frame_tick_q & (pending_q | press | auto_req);
        pending_d = frame_tick_q ? 1'b0 : (pending_q | press | auto_req);
        pat_id_d  = pat_id_q;
        if (commit) begin
            pat_id_d = (pat_id_q == 3'd5) ? 3'd0 : pat_id_q + 3'd1;
            fcnt_d   = '0;
        end
    end

    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (lcd.pix_x >= 10'(k * BAR_W)) begin
                bar_idx = bar_idx + 3'd1;
            end
        end

        case (bar_idx)
            3'd0:    bar_rgb = 16'hFFFF;
            3'd1:    bar_rgb = 16'hFFE0;
            3'd2:    bar_rgb = 16'h07FF;
            3'd3:    bar_rgb = 16'h07E0;
            3'd4:    bar_rgb = 16'hF81F;
            3'd5:    bar_rgb = 16'hF800;
            3'd6:    bar_rgb = 16'h001F;
            default: bar_rgb = 16'h0000;
        endcase

        case (pat_id_q)
            3'd0:    pat_rgb = 16'hF800;
            3'd1:    pat_rgb = 16'h07E0;
            3'd2:    pat_rgb = 16'h001F;
            3'd3:    pat_rgb = bar_rgb;
            3'd4:    pat_rgb = (lcd.pix_x[5] ^ lcd.pix_y[5]) ? 16'hFFFF : 16'h0000;
            3'd5:    pat_rgb = {lcd.pix_x[7:3], lcd.pix_x[7:2], lcd.pix_x[7:3]};
            default: pat_rgb = 16'h0000;
        endcase

        pix_rgb_d = lcd.lcd_de ? pat_rgb : 16'h0000;
    end

    assign lcd.pix_rgb = pix_rgb_q;
    assign pat_id      = pat_id_q;
    assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_lcd_pattern_sched.sv
// Scoreboard bench for lcd_pattern_sched: stimulus queues expected pixels and
// committed pattern ids, a negedge monitor pops and compares them.
module tb_lcd_pattern_sched;

    localparam int H_ACT = 640;
    localparam int FPP   = 2;
    localparam int DEB   = 16;

    localparam logic [9:0] PX [8] = '{10'd0, 10'd31, 10'd32, 10'd32, 10'd79, 10'd80, 10'd255, 10'd639};
    localparam logic [9:0] PY [8] = '{10'd0, 10'd0,  10'd0,  10'd32, 10'd1,  10'd1,  10'd2,   10'd3};

    // Hand-computed RGB565 for each pattern at the eight probe points above.
    localparam logic [15:0] EXP_TBL [6][8] = '{
        '{16'hF800, 16'hF800, 16'hF800, 16'hF800, 16'hF800, 16'hF800, 16'hF800, 16'hF800},
        '{16'h07E0, 16'h07E0, 16'h07E0, 16'h07E0, 16'h07E0, 16'h07E0, 16'h07E0, 16'h07E0},
        '{16'h001F, 16'h001F, 16'h001F, 16'h001F, 16'h001F, 16'h001F, 16'h001F, 16'h001F},
        '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFE0, 16'h07E0, 16'h0000},
        '{16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF},
        '{16'h0000, 16'h18E3, 16'h2104, 16'h2104, 16'h4A69, 16'h528A, 16'hFFFF, 16'h7BEF}
    };

    localparam logic [2:0] AUTO_SEQ [13] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3,
                                            3'd4, 3'd4, 3'd5, 3'd5, 3'd0, 3'd0};

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       auto_en = 1'b0;
    logic       key_n   = 1'b1;
    logic [2:0] pat_id;
    logic       frame_tick;

    logic       rst_pipe = 1'b0;
    logic       de_pipe  = 1'b0;
    logic       done     = 1'b0;

    logic [15:0] pix_q [$];
    logic [2:0]  pat_q [$];

    int checks   = 0;
    int failures = 0;

    lcd_pattern_sched_if lcd ();

    lcd_pattern_sched #(
        .H_ACT          (H_ACT),
        .FRAMES_PER_PAT (FPP),
        .DEB_CYCLES     (DEB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lcd        (lcd),
        .auto_en    (auto_en),
        .key_n      (key_n),
        .pat_id     (pat_id),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Mirror the DUT's one-cycle pixel latency so the monitor knows when a pixel is due.
    always @(posedge clk) begin
        rst_pipe <= rst;
        de_pipe  <= lcd.lcd_de;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pixels(input logic [2:0] exp_pat);
        for (int i = 0; i < 8; i++) begin
            lcd.lcd_de = 1'b1;
            lcd.pix_x  = PX[i];
            lcd.pix_y  = PY[i];
            pix_q.push_back(EXP_TBL[exp_pat][i]);
            next_cycle();
        end
        lcd.lcd_de = 1'b0;
    endtask

    // One short frame; key_lead lowers key_n so its acceptance lands on the tick cycle.
    task automatic apply_stimulus(input logic [2:0] exp_pat, input bit key_lead);
        pat_q.push_back(exp_pat);
        if (key_lead) begin
            key_n = 1'b0;
            repeat (DEB) next_cycle();
        end
        lcd.lcd_vsy = 1'b0;
        repeat (3) next_cycle();
        lcd.lcd_vsy = 1'b1;
        repeat (2) next_cycle();
        drive_pixels(exp_pat);
        repeat (3) next_cycle();
    endtask

    task automatic key_pulse(input int low_cycles, input int high_cycles);
        key_n = 1'b0;
        repeat (low_cycles) next_cycle();
        key_n = 1'b1;
        repeat (high_cycles) next_cycle();
    endtask

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    initial begin
        lcd.lcd_vsy = 1'b1;
        lcd.lcd_de  = 1'b0;
        lcd.pix_x   = 10'd0;
        lcd.pix_y   = 10'd0;

        repeat (3) next_cycle();
        rst = 1'b1;
        next_cycle();

        $display("[TB] idle after reset");
        apply_stimulus(3'd0, 1'b0);
        apply_stimulus(3'd0, 1'b0);

        $display("[TB] auto advance");
        auto_en = 1'b1;
        for (int f = 0; f < 13; f++) apply_stimulus(AUTO_SEQ[f], 1'b0);

        $display("[TB] debounce");
        auto_en = 1'b0;
        next_cycle();
        apply_stimulus(3'd0, 1'b0);
        key_pulse(10, 20);
        key_pulse(10, 20);
        apply_stimulus(3'd0, 1'b0);
        key_pulse(40, 30);
        apply_stimulus(3'd1, 1'b0);
        apply_stimulus(3'd1, 1'b0);

        $display("[TB] simultaneous requests");
        auto_en = 1'b1;
        apply_stimulus(3'd1, 1'b0);
        key_pulse(40, 30);
        apply_stimulus(3'd2, 1'b0);
        apply_stimulus(3'd3, 1'b1);
        key_n = 1'b1;
        repeat (30) next_cycle();
        apply_stimulus(3'd3, 1'b0);
        apply_stimulus(3'd4, 1'b0);

        $display("[TB] reset mid-frame with pending advance");
        key_pulse(40, 30);
        drive_pixels(3'd4);
        lcd.lcd_de = 1'b1;
        lcd.pix_x  = 10'd32;
        lcd.pix_y  = 10'd0;
        rst        = 1'b0;
        auto_en    = 1'b0;
        repeat (2) next_cycle();
        rst        = 1'b1;
        lcd.lcd_de = 1'b0;
        next_cycle();
        apply_stimulus(3'd0, 1'b0);
        apply_stimulus(3'd0, 1'b0);

        repeat (5) next_cycle();
        done = 1'b1;
    end

    initial begin
        logic [2:0]  cur_pat;
        logic        tick_prev;
        logic [15:0] exp_pix;
        logic [2:0]  exp_pat;
        cur_pat   = 3'd0;
        tick_prev = 1'b0;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            @(negedge clk);
            if (!rst_pipe) begin
                check_output("rst_pix", lcd.pix_rgb, 16'h0000);
                check_output("rst_pat", {13'b0, pat_id}, 16'h0000);
                check_output("rst_tick", {15'b0, frame_tick}, 16'h0000);
                cur_pat   = 3'd0;
                tick_prev = 1'b0;
            end else begin
                if (tick_prev) begin
                    if (pat_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL pat_commit: unexpected frame_tick, got pat_id %0d required no tick", pat_id);
                    end else begin
                        exp_pat = pat_q.pop_front();
                        check_output("pat_commit", {13'b0, pat_id}, {13'b0, exp_pat});
                        cur_pat = exp_pat;
                    end
                end else begin
                    check_output("pat_hold", {13'b0, pat_id}, {13'b0, cur_pat});
                end
                if (de_pipe) begin
                    if (pix_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL pix: unexpected pixel, got %h required none", lcd.pix_rgb);
                    end else begin
                        exp_pix = pix_q.pop_front();
                        check_output("pix", lcd.pix_rgb, exp_pix);
                    end
                end else begin
                    check_output("blank", lcd.pix_rgb, 16'h0000);
                end
                tick_prev = frame_tick;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL watchdog: got done=0 required done=1");
        end
        check_output("pix_q_drained", 16'(pix_q.size()), 16'h0000);
        check_output("pat_q_drained", 16'(pat_q.size()), 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_pattern_sched.md
# lcd_pattern_sched

Test-pattern scheduler for the 16-bit RGB565 LCD path, clocked on the 25 MHz PLL clock alongside `lcd_ctrl`. It detects frame boundaries from the LCD vertical sync and chooses which of six test patterns is shown. Pattern changes happen automatically every N frames or on a debounced push-button press, and are always committed at a frame boundary. For each active pixel it produces the RGB565 word from the pixel coordinates supplied by the timing generator.

## Interface
Parameters:
- `H_ACT`, 640: active pixels per line; colour-bar width is `H_ACT/8`.
- `FRAMES_PER_PAT`, 60: frames each pattern is shown in auto mode (must be ≥1).
- `DEB_CYCLES`, 250000: number of stable cycles before a key level is accepted (10 ms at 25 MHz).

Ports:
- `clk` in 1: 25 MHz pixel clock.
- `rst` in 1: reset, synchronous, active-low.
- `lcd_vsy` in 1: vertical sync from the timing generator, active-low.
- `lcd_de` in 1: active-pixel strobe from the timing generator.
- `pix_x` in 10: column of the current active pixel, range 0..H_ACT-1.
- `pix_y` in 10: row of the current active pixel.
- `auto_en` in 1: 1 = advance automatically every `FRAMES_PER_PAT` frames; 0 = hold the current pattern.
- `key_n` in 1: raw push-button, active-low, asynchronous to `clk`.
- `pix_rgb` out 16: RGB565 pixel as {r[4:0], g[5:0], b[4:0]}.
- `pat_id` out 3: pattern currently displayed, range 0..5.
- `frame_tick` out 1: one-cycle pulse at each frame boundary.

## Operation
- Frame boundary: `lcd_vsy` is registered. A falling edge (previous 1, current 0) asserts `frame_tick` for 1 cycle.
- Key path:
  - `key_n` passes through a 2-FF synchroniser.
  - Debounce counter: resets to 0 whenever the synchronised level equals the accepted level. Otherwise it increments, and when it reaches `DEB_CYCLES-1` the accepted level takes the synchronised value.
  - A press is an accepted-level transition 1→0. The accepted level resets to 1.
- Frame counter `fcnt`:
  - Counts `frame_tick` events while `auto_en`=1.
  - At `FRAMES_PER_PAT-1`, the next tick wraps it to 0 and raises the advance request.
  - While `auto_en`=0, it is held at 0.
- Pending flag:
  - Set by a press or by an auto request.
  - Cleared on a `frame_tick`, and that same tick sets `pat_id` ← (`pat_id`==5 ? 0 : `pat_id`+1).
  - Multiple requests within one frame produce exactly one advance.
  - A request that coincides with `frame_tick` is committed at that tick.
  - Any `frame_tick` that commits an advance also clears `fcnt` to 0.
- Patterns (evaluated only when `lcd_de`=1):
  - 0: red, 16'hF800.
  - 1: green, 16'h07E0.
  - 2: blue, 16'h001F.
  - 3: eight vertical bars. Bar index = `pix_x`/(`H_ACT`/8), using a registered bar counter or comparator chain; no divider. Order: white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000.
  - 4: checkerboard with 32-pixel squares. `pix_x[5]^pix_y[5]` = 1 → FFFF, otherwise 0000.
  - 5: grey ramp repeating every 256 pixels: r=`pix_x[7:3]`, g=`pix_x[7:2]`, b=`pix_x[7:3]`.
- When `lcd_de`=0, `pix_rgb` = 0.

## Timing
- `pix_rgb` is registered, with 1-cycle latency from `lcd_de`/`pix_x`/`pix_y`. The timing generator delays its sync outputs by 1 cycle to stay aligned.
- `pat_id` changes only in the cycle after a `frame_tick` is registered, so the displayed pattern never changes mid-frame.
- Press latency: from `key_n` falling to the accepted press is 2 synchroniser cycles + `DEB_CYCLES`. The commit then happens at the next frame boundary.
- Reset (`rst`=0 sampled on a `clk` edge), including mid-frame:
  - `pix_rgb`=0, `pat_id`=0, `frame_tick`=0.
  - `fcnt`=0, pending=0, debounce counter=0, accepted key level=1.
  - Registered `lcd_vsy`=1, so a held-low vsync does not produce a spurious tick on release.
- `auto_en` toggling mid-frame has no effect on the current pattern until the next tick.

## Test plan
- Reset/idle:
  - Stimulus: `rst`=0 for 3 cycles, then run 2 frames with `auto_en`=0 and no key.
  - Required: `pat_id`=0 throughout; every active pixel is F800 one cycle after `lcd_de`; `pix_rgb`=0 during blanking.
- Auto advance:
  - Stimulus: `FRAMES_PER_PAT`=2, `auto_en`=1, run 13 frames.
  - Required: `pat_id` sequence 0,0,1,1,…,5,5,0; each change is exactly 1 cycle after a `frame_tick`.
- Debounce:
  - Stimulus: `DEB_CYCLES`=16. Apply 10-cycle low glitches on `key_n`, then a 40-cycle low press.
  - Required: the glitches cause no advance; the press causes exactly one advance, at the next tick.
- Simultaneous requests:
  - Stimulus: a press lands in the same frame as the auto wrap, and another press lands on the tick cycle itself.
  - Required: a single +1 advance per tick.
  - Required: `fcnt` restarts from 0.
- Pixel content:
  - Stimulus: pattern 3 at `H_ACT`=640, x=79/80/639. Pattern 4 at (31,0)/(32,0)/(32,32). Pattern 5 at x=255.
  - Required, pattern 3: FFFF, FFE0, 0000.
  - Required, pattern 4: 0000, FFFF, 0000.
  - Required, pattern 5: FFFF.
- Reset mid-frame:
  - Stimulus: assert `rst` during the active area while `pat_id`=4 and pending=1.
  - Required: the next cycle gives `pat_id`=0 and `pix_rgb`=0; the pending advance is discarded.
